// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the multicycle CPU control unit and datapath.
//   state_e    : control FSM state encoding
//   OP_*       : instruction opcodes (instruction[3:0])
//   SEL_*      : datapath bus source select codes
//   ENABLE_*   : r_enable bit indices for non-GPR registers (R0-R7 use bits 7:0)
//   decode_t   : decoded instruction fields handed from cpu_decode to cpu_control
package cpu_pkg;

    typedef enum logic [4:0] {
        S_FETCH_ADDR = 5'd0,
        S_FETCH_MEM  = 5'd1,
        S_FETCH_IR   = 5'd2,
        S_DECODE     = 5'd3,
        S_ALU_A      = 5'd4,
        S_ALU_OP     = 5'd5,
        S_ALU_WB     = 5'd6,
        S_LD_ADDR    = 5'd7,
        S_LD_MEM     = 5'd8,
        S_LD_WB      = 5'd9,
        S_ST_ADDR    = 5'd10,
        S_ST_DATA    = 5'd11,
        S_ST_WR      = 5'd12,
        S_CALL_LINK  = 5'd13,
        S_JR         = 5'd14,
        S_JI_A       = 5'd15,
        S_JI_OP      = 5'd16,
        S_JI_WB      = 5'd17
    } state_e;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd5;
    localparam logic [3:0] OP_MVHI = 4'd6;
    localparam logic [3:0] OP_J    = 4'd8;
    localparam logic [3:0] OP_JZ   = 4'd9;
    localparam logic [3:0] OP_JN   = 4'd10;
    localparam logic [3:0] OP_CALL = 4'd12;

    localparam logic [2:0] SEL_RX    = 3'd0;
    localparam logic [2:0] SEL_RY    = 3'd1;
    localparam logic [2:0] SEL_PC    = 3'd2;
    localparam logic [2:0] SEL_S     = 3'd3;
    localparam logic [2:0] SEL_IMM8  = 3'd4;
    localparam logic [2:0] SEL_IMM11 = 3'd5;
    localparam logic [2:0] SEL_MEM   = 3'd6;

    localparam int ENABLE_LINK   = 7;   // R7 receives the return address on call
    localparam int ENABLE_A      = 8;
    localparam int ENABLE_S      = 9;
    localparam int ENABLE_FLAGS  = 10;
    localparam int ENABLE_IR     = 11;
    localparam int ENABLE_ADDR   = 12;
    localparam int ENABLE_WRDATA = 13;
    localparam int ENABLE_PC     = 14;

    typedef struct packed {
        logic [2:0] rx;
        logic       imm;
        logic       is_mv;
        logic       is_mvhi;
        logic       is_alu;     // add, sub or cmp
        logic       is_cmp;
        logic       is_sub;     // sub or cmp: ALU subtracts
        logic       is_ld;
        logic       is_st;
        logic       is_call;
        logic       take_jump;  // j, or jz/jn whose flag condition holds
    } decode_t;

    // One-hot general-register enable for R[idx].
    function automatic logic [14:0] reg_onehot(input logic [2:0] idx);
        logic [14:0] v;
        v = 15'd0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// cpu_decode -- combinational instruction decode for cpu_control.
//   instruction : IR contents (opcode [3:0], imm flag [4], Rx [7:5])
//   N, Z        : registered flags, used for conditional jump resolution
//   dec         : decoded opcode class, register index and branch-taken bit
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [15:0] instruction,
    input  logic        N,
    input  logic        Z,
    output decode_t     dec
);

    logic [3:0] op;
    // Ry and the immediate fields only steer the datapath, not the sequencing.
    logic       unused_fields;

    assign op            = instruction[3:0];
    assign unused_fields = ^instruction[15:8];

    always_comb begin
        dec           = '0;
        dec.rx        = instruction[7:5];
        dec.imm       = instruction[4];
        dec.is_mv     = (op == OP_MV);
        dec.is_mvhi   = (op == OP_MVHI);
        dec.is_alu    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
        dec.is_cmp    = (op == OP_CMP);
        dec.is_sub    = (op == OP_SUB) || (op == OP_CMP);
        dec.is_ld     = (op == OP_LD);
        dec.is_st     = (op == OP_ST);
        dec.is_call   = (op == OP_CALL);
        dec.take_jump = (op == OP_J) || ((op == OP_JZ) && Z) || ((op == OP_JN) && N);
    end

endmodule

// File: rtl/cpu_control.sv
// cpu_control -- multicycle Moore control unit sequencing cpu_datapath.
//   clk, reset    : rising-edge clock, synchronous active-low reset
//   instruction   : IR contents; N, Z : registered flags
//   sel           : datapath bus source select
//   addsub        : ALU mode (0 add, 1 subtract)
//   pc_incr       : PC += 2 this edge
//   h             : register write targets the high byte (mvhi)
//   r_enable      : register write enables (R0-R7, A, S, flags, IR, ADDR, WRDATA, PC)
//   o_mem_rd      : memory read strobe, data valid the following cycle
//   o_mem_wr      : memory write of WRDATA to ADDR this edge
module cpu_control
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        N,
    input  logic        Z,
    output logic [2:0]  sel,
    output logic        addsub,
    output logic        pc_incr,
    output logic        h,
    output logic [14:0] r_enable,
    output logic        o_mem_rd,
    output logic        o_mem_wr
);

    decode_t dec;
    state_e  state_q, state_d;

    cpu_decode u_decode (
        .instruction (instruction),
        .N           (N),
        .Z           (Z),
        .dec         (dec)
    );

    // Jump entry shared by call (after linking) and taken branches.
    function automatic state_e jump_entry(input logic imm);
        return imm ? S_JI_A : S_JR;
    endfunction

    always_comb begin
        state_d = S_FETCH_ADDR;
        case (state_q)
            S_FETCH_ADDR: state_d = S_FETCH_MEM;
            S_FETCH_MEM:  state_d = S_FETCH_IR;
            S_FETCH_IR:   state_d = S_DECODE;
            S_DECODE: begin
                // mv/mvhi complete here; NOPs and untaken branches fall to fetch.
                if (dec.is_alu)         state_d = S_ALU_A;
                else if (dec.is_ld)     state_d = S_LD_ADDR;
                else if (dec.is_st)     state_d = S_ST_ADDR;
                else if (dec.is_call)   state_d = S_CALL_LINK;
                else if (dec.take_jump) state_d = jump_entry(dec.imm);
                else                    state_d = S_FETCH_ADDR;
            end
            S_ALU_A:      state_d = S_ALU_OP;
            S_ALU_OP:     state_d = dec.is_cmp ? S_FETCH_ADDR : S_ALU_WB;
            S_LD_ADDR:    state_d = S_LD_MEM;
            S_LD_MEM:     state_d = S_LD_WB;
            S_ST_ADDR:    state_d = S_ST_DATA;
            S_ST_DATA:    state_d = S_ST_WR;
            S_CALL_LINK:  state_d = jump_entry(dec.imm);
            S_JI_A:       state_d = S_JI_OP;
            S_JI_OP:      state_d = S_JI_WB;
            default:      state_d = S_FETCH_ADDR;  // last states and illegal encodings
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FETCH_ADDR;
        else        state_q <= state_d;
    end

    always_comb begin
        sel      = SEL_RX;
        addsub   = 1'b0;
        pc_incr  = 1'b0;
        h        = 1'b0;
        r_enable = '0;
        o_mem_rd = 1'b0;
        o_mem_wr = 1'b0;
        case (state_q)
            S_FETCH_ADDR: begin sel = SEL_PC; r_enable[ENABLE_ADDR] = 1'b1; end
            S_FETCH_MEM:  begin o_mem_rd = 1'b1; pc_incr = 1'b1; end
            S_FETCH_IR:   r_enable[ENABLE_IR] = 1'b1;
            S_DECODE: begin
                if (dec.is_mv) begin
                    sel      = dec.imm ? SEL_IMM8 : SEL_RY;
                    r_enable = reg_onehot(dec.rx);
                end else if (dec.is_mvhi) begin
                    sel      = SEL_IMM8;
                    h        = 1'b1;
                    r_enable = reg_onehot(dec.rx);
                end
            end
            S_ALU_A:      begin sel = SEL_RX; r_enable[ENABLE_A] = 1'b1; end
            S_ALU_OP: begin
                sel                     = dec.imm ? SEL_IMM8 : SEL_RY;
                addsub                  = dec.is_sub;
                r_enable[ENABLE_S]      = 1'b1;
                r_enable[ENABLE_FLAGS]  = 1'b1;
            end
            S_ALU_WB:     begin sel = SEL_S; r_enable = reg_onehot(dec.rx); end
            S_LD_ADDR:    begin sel = SEL_RY; r_enable[ENABLE_ADDR] = 1'b1; end
            S_LD_MEM:     o_mem_rd = 1'b1;
            S_LD_WB:      begin sel = SEL_MEM; r_enable = reg_onehot(dec.rx); end
            S_ST_ADDR:    begin sel = SEL_RY; r_enable[ENABLE_ADDR] = 1'b1; end
            S_ST_DATA:    begin sel = SEL_RX; r_enable[ENABLE_WRDATA] = 1'b1; end
            S_ST_WR:      o_mem_wr = 1'b1;
            S_CALL_LINK:  begin sel = SEL_PC; r_enable[ENABLE_LINK] = 1'b1; end
            S_JR:         begin sel = SEL_RX; r_enable[ENABLE_PC] = 1'b1; end
            // PC already points past the jump, so target = (instr addr + 2) + 2*imm11.
            S_JI_A:       begin sel = SEL_PC; r_enable[ENABLE_A] = 1'b1; end
            S_JI_OP:      begin sel = SEL_IMM11; r_enable[ENABLE_S] = 1'b1; end
            S_JI_WB:      begin sel = SEL_S; r_enable[ENABLE_PC] = 1'b1; end
            default: ;
        endcase
        // Reset cycle is fully quiet so an aborted instruction writes nothing.
        if (!reset) begin
            sel      = SEL_RX;
            addsub   = 1'b0;
            pc_incr  = 1'b0;
            h        = 1'b0;
            r_enable = '0;
            o_mem_rd = 1'b0;
            o_mem_wr = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control -- self-checking bench for cpu_control. Each instruction is
// expanded into its list of per-cycle control words from the opcode table,
// and the DUT outputs are compared against that list every cycle.
module tb_cpu_control;

    typedef struct packed {
        logic [2:0]  sel;
        logic        addsub;
        logic        pc_incr;
        logic        h;
        logic [14:0] en;
        logic        rd;
        logic        wr;
    } out_t;

    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic        N, Z;
    logic [2:0]  sel;
    logic        addsub, pc_incr, h, o_mem_rd, o_mem_wr;
    logic [14:0] r_enable;

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];
    out_t got[0:15];

    cpu_control dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .N           (N),
        .Z           (Z),
        .sel         (sel),
        .addsub      (addsub),
        .pc_incr     (pc_incr),
        .h           (h),
        .r_enable    (r_enable),
        .o_mem_rd    (o_mem_rd),
        .o_mem_wr    (o_mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic [2:0] s, input logic as, input logic pi,
                                input logic hh, input logic [14:0] e,
                                input logic r, input logic w);
        out_t o;
        o = '{sel: s, addsub: as, pc_incr: pi, h: hh, en: e, rd: r, wr: w};
        return o;
    endfunction

    function automatic out_t sample();
        return mk(sel, addsub, pc_incr, h, r_enable, o_mem_rd, o_mem_wr);
    endfunction

    // Expected control words, one per cycle, for a complete instruction.
    task automatic build_exp(input logic [15:0] ins, input logic n, input logic z);
        int          op;
        logic        imm;
        logic [14:0] rx_en;
        logic        do_jump;
        op      = int'(ins[3:0]);
        imm     = ins[4];
        rx_en   = 15'd1 << ins[7:5];
        do_jump = 1'b0;
        exp_q.delete();
        exp_q.push_back(mk(3'd2, 0, 0, 0, 15'h1000, 0, 0));   // fetch address
        exp_q.push_back(mk(3'd0, 0, 1, 0, 15'h0000, 1, 0));   // fetch memory
        exp_q.push_back(mk(3'd0, 0, 0, 0, 15'h0800, 0, 0));   // load IR
        if (op == 0)      exp_q.push_back(mk(imm ? 3'd4 : 3'd1, 0, 0, 0, rx_en, 0, 0));
        else if (op == 6) exp_q.push_back(mk(3'd4, 0, 0, 1, rx_en, 0, 0));
        else              exp_q.push_back('0);
        case (op)
            1, 2, 3: begin
                exp_q.push_back(mk(3'd0, 0, 0, 0, 15'h0100, 0, 0));
                exp_q.push_back(mk(imm ? 3'd4 : 3'd1, op != 1, 0, 0, 15'h0600, 0, 0));
                if (op != 3) exp_q.push_back(mk(3'd3, 0, 0, 0, rx_en, 0, 0));
            end
            4: begin
                exp_q.push_back(mk(3'd1, 0, 0, 0, 15'h1000, 0, 0));
                exp_q.push_back(mk(3'd0, 0, 0, 0, 15'h0000, 1, 0));
                exp_q.push_back(mk(3'd6, 0, 0, 0, rx_en, 0, 0));
            end
            5: begin
                exp_q.push_back(mk(3'd1, 0, 0, 0, 15'h1000, 0, 0));
                exp_q.push_back(mk(3'd0, 0, 0, 0, 15'h2000, 0, 0));
                exp_q.push_back(mk(3'd0, 0, 0, 0, 15'h0000, 0, 1));
            end
            12: begin
                exp_q.push_back(mk(3'd2, 0, 0, 0, 15'h0080, 0, 0));
                do_jump = 1'b1;
            end
            8:  do_jump = 1'b1;
            9:  do_jump = z;
            10: do_jump = n;
            default: ;
        endcase
        if (do_jump) begin
            if (imm) begin
                exp_q.push_back(mk(3'd2, 0, 0, 0, 15'h0100, 0, 0));
                exp_q.push_back(mk(3'd5, 0, 0, 0, 15'h0200, 0, 0));
                exp_q.push_back(mk(3'd3, 0, 0, 0, 15'h4000, 0, 0));
            end else begin
                exp_q.push_back(mk(3'd0, 0, 0, 0, 15'h4000, 0, 0));
            end
        end
    endtask

    task automatic check_out(input string name, input int cyc, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle %0d got sel=%0d as=%b pi=%b h=%b en=%h rd=%b wr=%b want sel=%0d as=%b pi=%b h=%b en=%h rd=%b wr=%b",
                     name, cyc, a.sel, a.addsub, a.pc_incr, a.h, a.en, a.rd, a.wr,
                     e.sel, e.addsub, e.pc_incr, e.h, e.en, e.rd, e.wr);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, a, e);
        end
    endtask

    // Runs one instruction from FETCH_ADDR; abort_at >= 0 pulls reset in that cycle.
    task automatic run_instr(input logic [15:0] ins, input logic n, input logic z,
                             input int abort_at);
        out_t s;
        build_exp(ins, n, z);
        N = n;
        Z = z;
        for (int i = 0; i < exp_q.size(); i++) begin
            // During fetch the IR still holds unrelated bits.
            instruction = (i < 3) ? 16'($urandom) : ins;
            if (i == abort_at) begin
                reset = 1'b0;
                @(negedge clk);
                check_out("reset_quiet", i, sample(), '0);
                @(posedge clk);
                #1;
                reset = 1'b1;
                return;
            end
            @(negedge clk);
            s = sample();
            got[i] = s;
            check_out("seq", i, s, exp_q[i]);
            check_int("rd_wr_excl", int'(s.rd & s.wr), 0);
            check_int("pcinc_pcen_excl", int'(s.pc_incr & s.en[14]), 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int ab;
        reset       = 1'b0;
        instruction = 16'h0000;
        N           = 1'b0;
        Z           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        instruction = 16'hFFFF;
        @(negedge clk);
        check_out("reset_state", 0, sample(), '0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Model pins: instruction lengths from the cycle table.
        build_exp(16'h0003, 0, 0); check_int("len_cmp", exp_q.size(), 6);
        build_exp(16'h0001, 0, 0); check_int("len_add", exp_q.size(), 7);
        build_exp(16'h0018, 0, 0); check_int("len_jimm", exp_q.size(), 7);
        build_exp(16'h0008, 0, 0); check_int("len_jreg", exp_q.size(), 5);
        build_exp(16'h001C, 0, 0); check_int("len_callimm", exp_q.size(), 8);
        build_exp(16'h000C, 0, 0); check_int("len_callreg", exp_q.size(), 6);
        build_exp(16'h000F, 0, 0); check_int("len_nop", exp_q.size(), 4);

        // mv R3,#0x12
        run_instr(16'h1270, 0, 0, -1);
        check_int("mv_len", exp_q.size(), 4);
        check_int("mv_sel", int'(got[3].sel), 4);
        check_int("mv_en", int'(got[3].en), 16'h0008);
        check_int("fetch_addr_en", int'(got[0].en), 16'h1000);
        check_int("fetch_mem_rd_pc", int'({got[1].rd, got[1].pc_incr}), 3);

        // sub R1,R2
        run_instr(16'h0222, 0, 0, -1);
        check_int("sub_len", exp_q.size(), 7);
        check_int("sub_addsub", int'(got[5].addsub), 1);
        check_int("sub_op_en", int'(got[5].en), 16'h0600);
        check_int("sub_wb_en", int'(got[6].en), 16'h0002);

        // st R4,[R5] then ld R6,[R5]
        run_instr(16'h0585, 0, 0, -1);
        check_int("st_wr", int'({got[6].wr, got[6].rd}), 2);
        run_instr(16'h05C4, 0, 0, -1);
        check_int("ld_rd", int'(got[5].rd), 1);
        check_int("ld_wb_sel", int'(got[6].sel), 6);
        check_int("ld_wb_en", int'(got[6].en), 16'h0040);

        // jz imm, not taken then taken
        run_instr(16'h0019, 0, 0, -1);
        check_int("jz_nt_len", exp_q.size(), 4);
        run_instr(16'h0019, 0, 1, -1);
        check_int("jz_t_len", exp_q.size(), 7);
        check_int("jz_t_wb_en", int'(got[6].en), 16'h4000);

        // call imm
        run_instr(16'h001C, 0, 0, -1);
        check_int("call_link_sel", int'(got[4].sel), 2);
        check_int("call_link_en", int'(got[4].en), 16'h0080);
        check_int("call_len", exp_q.size(), 8);

        // reset during ALU_OP of add, then a clean mv from FETCH_ADDR
        run_instr(16'h0221, 0, 0, 5);
        run_instr(16'h0070, 0, 0, -1);

        // Randomized instruction stream with occasional mid-instruction resets.
        for (int k = 0; k < 400; k++) begin
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr(16'($urandom), 1'($urandom), 1'($urandom), ab);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
